// File: rtl/rtc_alarm_clock.sv
// HH:MM:SS clock with prescaler, runtime set, 12/24h display and a single alarm
// with ringing/snooze states, snooze re-arm and ring auto-timeout.
module rtc_alarm_clock #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned SNOOZE_MIN    = 5,
  parameter int unsigned RING_MAX_MIN  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_12h,
  input  logic        set_en,
  input  logic [4:0]  set_hours,
  input  logic [5:0]  set_minutes,
  input  logic [5:0]  set_seconds,
  input  logic        alarm_wr,
  input  logic [4:0]  alarm_hours,
  input  logic [5:0]  alarm_minutes,
  input  logic        alarm_en,
  input  logic        snooze,
  input  logic        alarm_ack,
  output logic [5:0]  seconds,
  output logic [5:0]  minutes,
  output logic [4:0]  hours,
  output logic [4:0]  disp_hours,
  output logic        pm,
  output logic [15:0] bcd_time,
  output logic        sec_pulse,
  output logic        blink,
  output logic        set_err,
  output logic        alarm_active
);

  localparam int unsigned PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] SNZ_ADD    = 7'(SNOOZE_MIN);
  localparam logic [5:0] RING_LAST  = 6'(RING_MAX_MIN - 1);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [4:0]    alarm_h_q, alarm_h_d;
  logic [5:0]    alarm_m_q, alarm_m_d;
  logic [4:0]    snz_h_q, snz_h_d;
  logic [5:0]    snz_m_q, snz_m_d;
  logic [5:0]    ring_cnt_q, ring_cnt_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          set_err_q, set_err_d;
  logic          alarm_active_q, alarm_active_d;

  logic       tick, time_ok, alarm_ok, set_load, adv, sec_wrap, min_wrap, min_carry;
  logic       match_alarm, match_snz;
  logic [5:0] inc_sec, inc_min, tgt_m;
  logic [4:0] inc_hr, tgt_h, disp_h;
  logic [6:0] snz_sum;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [7:0] r;
    r[7:4] = 4'(v / 6'd10);
    r[3:0] = 4'(v % 6'd10);
    return r;
  endfunction

  // Timekeeping datapath: prescaler, advance/carry, set and alarm register loads
  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    time_ok   = (set_hours <= 5'd23) && (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
    alarm_ok  = (alarm_hours <= 5'd23) && (alarm_minutes <= 6'd59);
    set_load  = set_en && time_ok;
    adv       = tick && !set_load;
    sec_wrap  = (sec_q == 6'd59);
    min_wrap  = (min_q == 6'd59);
    min_carry = adv && sec_wrap;
    inc_sec   = sec_wrap ? 6'd0 : sec_q + 6'd1;
    inc_min   = sec_wrap ? (min_wrap ? 6'd0 : min_q + 6'd1) : min_q;
    inc_hr    = (sec_wrap && min_wrap) ? ((hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1) : hr_q;

    presc_d   = tick ? '0 : presc_q + PW'(1);
    sec_d     = sec_q;
    min_d     = min_q;
    hr_d      = hr_q;
    alarm_h_d = alarm_h_q;
    alarm_m_d = alarm_m_q;
    if (set_load) begin
      presc_d = '0;
      sec_d   = set_seconds;
      min_d   = set_minutes;
      hr_d    = set_hours;
    end else if (tick) begin
      sec_d = inc_sec;
      min_d = inc_min;
      hr_d  = inc_hr;
    end
    if (alarm_wr && alarm_ok) begin
      alarm_h_d = alarm_hours;
      alarm_m_d = alarm_minutes;
    end
    sec_pulse_d = adv;
    set_err_d   = (set_en && !time_ok) || (alarm_wr && !alarm_ok);

    match_alarm = adv && (inc_hr == alarm_h_q) && (inc_min == alarm_m_q) && (inc_sec == 6'd0);
    match_snz   = adv && (inc_hr == snz_h_q) && (inc_min == snz_m_q) && (inc_sec == 6'd0);

    // Snooze target is the current time plus SNOOZE_MIN, wrapping through midnight
    snz_sum = 7'(min_q) + SNZ_ADD;
    if (snz_sum >= 7'd60) begin
      tgt_m = 6'(snz_sum - 7'd60);
      tgt_h = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
    end else begin
      tgt_m = 6'(snz_sum);
      tgt_h = hr_q;
    end
  end

  // Alarm FSM: priority !alarm_en > ack > snooze > timeout > match
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_h_d    = snz_h_q;
    snz_m_d    = snz_m_q;
    case (state_q)
      IDLE: begin
        if (alarm_en && match_alarm) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end
      RINGING: begin
        if (!alarm_en || alarm_ack) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d = SNOOZE;
          snz_h_d = tgt_h;
          snz_m_d = tgt_m;
        end else if (min_carry) begin
          if (ring_cnt_q == RING_LAST) state_d = IDLE;
          else ring_cnt_d = ring_cnt_q + 6'd1;
        end
      end
      SNOOZE: begin
        if (!alarm_en || alarm_ack) begin
          state_d = IDLE;
        end else if (match_snz) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    alarm_active_d = (state_d == RINGING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      sec_q          <= '0;
      min_q          <= '0;
      hr_q           <= '0;
      alarm_h_q      <= '0;
      alarm_m_q      <= '0;
      snz_h_q        <= '0;
      snz_m_q        <= '0;
      ring_cnt_q     <= '0;
      sec_pulse_q    <= 1'b0;
      set_err_q      <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      sec_q          <= sec_d;
      min_q          <= min_d;
      hr_q           <= hr_d;
      alarm_h_q      <= alarm_h_d;
      alarm_m_q      <= alarm_m_d;
      snz_h_q        <= snz_h_d;
      snz_m_q        <= snz_m_d;
      ring_cnt_q     <= ring_cnt_d;
      sec_pulse_q    <= sec_pulse_d;
      set_err_q      <= set_err_d;
      alarm_active_q <= alarm_active_d;
    end
  end

  // Display formatting is a pure decode of the time registers
  always_comb begin
    if (hr_q == 5'd0)       disp_h = 5'd12;
    else if (hr_q > 5'd12)  disp_h = hr_q - 5'd12;
    else                    disp_h = hr_q;
    disp_hours = mode_12h ? disp_h : hr_q;
    pm         = (hr_q >= 5'd12);
    bcd_time   = {to_bcd(6'(disp_hours)), to_bcd(min_q)};
  end

  assign seconds      = sec_q;
  assign minutes      = min_q;
  assign hours        = hr_q;
  assign blink        = sec_q[0];
  assign sec_pulse    = sec_pulse_q;
  assign set_err      = set_err_q;
  assign alarm_active = alarm_active_q;

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Directed bench for rtc_alarm_clock with a 4-cycle prescaler, 5 min snooze, 10 min ring limit.
module tb_rtc_alarm_clock;

  localparam int unsigned TPS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode_12h, set_en, alarm_wr, alarm_en, snooze, alarm_ack;
  logic [4:0]  set_hours, alarm_hours;
  logic [5:0]  set_minutes, set_seconds, alarm_minutes;
  logic [5:0]  seconds, minutes;
  logic [4:0]  hours, disp_hours;
  logic        pm, sec_pulse, blink, set_err, alarm_active;
  logic [15:0] bcd_time;

  int checks = 0;
  int errors = 0;

  rtc_alarm_clock #(.TICKS_PER_SEC(TPS), .SNOOZE_MIN(5), .RING_MAX_MIN(10)) dut (
    .clk(clk), .reset(reset), .mode_12h(mode_12h),
    .set_en(set_en), .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .alarm_wr(alarm_wr), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_en(alarm_en), .snooze(snooze), .alarm_ack(alarm_ack),
    .seconds(seconds), .minutes(minutes), .hours(hours), .disp_hours(disp_hours),
    .pm(pm), .bcd_time(bcd_time), .sec_pulse(sec_pulse), .blink(blink),
    .set_err(set_err), .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;

  task automatic drive_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    @(negedge clk);
    set_en = 1'b1; set_hours = h; set_minutes = m; set_seconds = s;
    @(negedge clk);
    set_en = 1'b0;
  endtask

  task automatic drive_alarm(input logic [4:0] h, input logic [5:0] m);
    @(negedge clk);
    alarm_wr = 1'b1; alarm_hours = h; alarm_minutes = m;
    @(negedge clk);
    alarm_wr = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({seconds, minutes, hours, disp_hours, pm, bcd_time, sec_pulse, blink, set_err, alarm_active} !== '0) begin
      errors++; $display("FAIL reset_24h: got s=%0d m=%0d h=%0d dh=%0d bcd=%h act=%b, required all zero",
                         seconds, minutes, hours, disp_hours, bcd_time, alarm_active);
    end
    mode_12h = 1'b1;
    #1; checks++;
    if (disp_hours !== 5'd12 || bcd_time !== 16'h1200 || pm !== 1'b0) begin
      errors++; $display("FAIL reset_12h: got dh=%0d bcd=%h pm=%b, required 12 1200 0", disp_hours, bcd_time, pm);
    end
    mode_12h = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (sec_pulse !== ((i % TPS) == 0) || seconds !== 6'(i / TPS) || blink !== 1'(i / TPS)) begin
        errors++; $display("FAIL prescale cyc%0d: got pulse=%b sec=%0d blink=%b, required %b %0d %b",
                           i, sec_pulse, seconds, blink, (i % TPS) == 0, i / TPS, 1'(i / TPS));
      end
    end
  endtask

  task automatic test_rollover;
    drive_set(5'd23, 6'd59, 6'd58);
    checks++;
    if (sec_pulse !== 1'b0 || {hours, minutes, seconds} !== {5'd23, 6'd59, 6'd58}) begin
      errors++; $display("FAIL set_load: got %0d:%0d:%0d pulse=%b, required 23:59:58 0", hours, minutes, seconds, sec_pulse);
    end
    repeat (TPS) @(negedge clk);
    checks++;
    if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59}) begin
      errors++; $display("FAIL tick_59: got %0d:%0d:%0d, required 23:59:59", hours, minutes, seconds);
    end
    repeat (TPS) @(negedge clk);
    checks++;
    if ({hours, minutes, seconds} !== '0 || sec_pulse !== 1'b1) begin
      errors++; $display("FAIL midnight: got %0d:%0d:%0d pulse=%b, required 0:0:0 1", hours, minutes, seconds, sec_pulse);
    end
    mode_12h = 1'b1;
    #1; checks++;
    if (disp_hours !== 5'd12 || pm !== 1'b0 || bcd_time !== 16'h1200) begin
      errors++; $display("FAIL midnight_12h: got dh=%0d pm=%b bcd=%h, required 12 0 1200", disp_hours, pm, bcd_time);
    end
  endtask

  task automatic test_12h_and_errors;
    drive_set(5'd13, 6'd5, 6'd0);
    checks++;
    if (disp_hours !== 5'd1 || pm !== 1'b1 || bcd_time !== 16'h0105) begin
      errors++; $display("FAIL pm_12h: got dh=%0d pm=%b bcd=%h, required 1 1 0105", disp_hours, pm, bcd_time);
    end
    mode_12h = 1'b0;
    #1; checks++;
    if (disp_hours !== 5'd13 || pm !== 1'b1 || bcd_time !== 16'h1305) begin
      errors++; $display("FAIL pm_24h: got dh=%0d pm=%b bcd=%h, required 13 1 1305", disp_hours, pm, bcd_time);
    end
    drive_set(5'd24, 6'd10, 6'd10);
    checks++;
    if (set_err !== 1'b1 || {hours, minutes, seconds} !== {5'd13, 6'd5, 6'd0}) begin
      errors++; $display("FAIL bad_set: got err=%b %0d:%0d:%0d, required 1 13:5:0", set_err, hours, minutes, seconds);
    end
    @(negedge clk);
    checks++;
    if (set_err !== 1'b0) begin
      errors++; $display("FAIL err_strobe: got err=%b, required 0", set_err);
    end
    drive_alarm(5'd7, 6'd60);
    checks++;
    if (set_err !== 1'b1) begin
      errors++; $display("FAIL bad_alarm: got err=%b, required 1", set_err);
    end
    // a valid set on the same edge as a tick loads the new time with no pulse
    drive_set(5'd10, 6'd20, 6'd30);
    repeat (TPS - 1) @(negedge clk);
    set_en = 1'b1; set_hours = 5'd4; set_minutes = 6'd44; set_seconds = 6'd44;
    @(negedge clk);
    set_en = 1'b0;
    checks++;
    if (sec_pulse !== 1'b0 || {hours, minutes, seconds} !== {5'd4, 6'd44, 6'd44}) begin
      errors++; $display("FAIL set_vs_tick: got %0d:%0d:%0d pulse=%b, required 4:44:44 0", hours, minutes, seconds, sec_pulse);
    end
  endtask

  task automatic test_alarm;
    drive_alarm(5'd7, 6'd30);
    alarm_en = 1'b1;
    drive_set(5'd7, 6'd30, 6'd0);
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++; $display("FAIL load_no_ring: got act=%b, required 0", alarm_active);
    end
    drive_set(5'd7, 6'd29, 6'd59);
    repeat (TPS) @(negedge clk);
    checks++;
    if (alarm_active !== 1'b1 || {hours, minutes, seconds} !== {5'd7, 6'd30, 6'd0}) begin
      errors++; $display("FAIL alarm_ring: got act=%b %0d:%0d:%0d, required 1 7:30:0", alarm_active, hours, minutes, seconds);
    end
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++; $display("FAIL alarm_ack: got act=%b, required 0", alarm_active);
    end
  endtask

  task automatic test_snooze;
    int n;
    drive_alarm(5'd23, 6'd58);
    drive_set(5'd23, 6'd57, 6'd59);
    repeat (TPS) @(negedge clk);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++; $display("FAIL snz_ring: got act=%b, required 1", alarm_active);
    end
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++; $display("FAIL snz_enter: got act=%b, required 0", alarm_active);
    end
    n = 0;
    while (alarm_active !== 1'b1 && n < 400 * TPS) begin @(negedge clk); n++; end
    checks++;
    if (alarm_active !== 1'b1 || {hours, minutes, seconds} !== {5'd0, 6'd3, 6'd0}) begin
      errors++; $display("FAIL snz_rering: got act=%b %0d:%0d:%0d, required 1 0:3:0", alarm_active, hours, minutes, seconds);
    end
    n = 0;
    while (alarm_active !== 1'b0 && n < 700 * TPS) begin @(negedge clk); n++; end
    checks++;
    if (alarm_active !== 1'b0 || {hours, minutes, seconds} !== {5'd0, 6'd13, 6'd0}) begin
      errors++; $display("FAIL ring_timeout: got act=%b %0d:%0d:%0d, required 0 0:13:0", alarm_active, hours, minutes, seconds);
    end
  endtask

  task automatic test_disable_and_async_reset;
    drive_set(5'd23, 6'd57, 6'd59);
    repeat (TPS) @(negedge clk);
    alarm_en = 1'b0;
    @(negedge clk);
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++; $display("FAIL disable: got act=%b, required 0", alarm_active);
    end
    alarm_en = 1'b1;
    drive_set(5'd23, 6'd57, 6'd59);
    repeat (TPS) @(negedge clk);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++; $display("FAIL rering: got act=%b, required 1", alarm_active);
    end
    #1 reset = 1'b1;
    #1; checks++;
    if (alarm_active !== 1'b0 || {hours, minutes, seconds} !== '0) begin
      errors++; $display("FAIL async_reset: got act=%b %0d:%0d:%0d, required 0 0:0:0", alarm_active, hours, minutes, seconds);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode_12h = 1'b0; set_en = 1'b0; alarm_wr = 1'b0; alarm_en = 1'b0;
    snooze = 1'b0; alarm_ack = 1'b0;
    set_hours = '0; set_minutes = '0; set_seconds = '0; alarm_hours = '0; alarm_minutes = '0;
    test_reset;
    test_rollover;
    test_12h_and_errors;
    test_alarm;
    test_snooze;
    test_disable_and_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
